mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Data-memory access stage feeding the MEM/WB pipeline register. Loads and
// stores take MEM_LAT cycles; while an access is in flight the stage raises
// Stall so upstream holds its inputs steady, and it pushes bubbles into the
// write-back register. Non-memory instructions pass through in one cycle.
//
// Parameters
//   MEM_WORDS  data memory depth in 32-bit words (power of two, 4..1024)
//   MEM_LAT    cycles per memory access (1..8)
//
// Optional feature
//   MEM_ALIGN_CHECK_EN  when defined, an access whose address has nonzero
//                       low two bits skips memory, completes in one cycle
//                       and raises MisalignREG for that output cycle.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   RegWrite, MemToReg    write-back controls from EX/MEM
//   MemRead, MemWrite     memory controls (both set = store)
//   ALUresult             byte address for accesses, pass-through value else
//   ReadData2             store data
//   intr2011              destination register number
//   Stall                 hold request to upstream stages (combinational)
//   RegWriteREG, MemToRegREG, ReadDataREG, ALUresultREG, intr2011REG,
//   MisalignREG           registered write-back outputs
//   state_dbg             FSM state (1 = BUSY), for observation only
//
// Handshake: Stall=1 means "this cycle's inputs were not consumed; present
// them again unchanged next cycle". Inputs are consumed in the cycle where
// Stall=0. There is no valid/ready pair; every cycle carries an instruction.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int MEM_WORDS = 64,
    parameter int MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic        MemToReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUresult,
    input  logic [31:0] ReadData2,
    input  logic [4:0]  intr2011,
    output logic        Stall,
    output logic        RegWriteREG,
    output logic        MemToRegREG,
    output logic [31:0] ReadDataREG,
    output logic [31:0] ALUresultREG,
    output logic [4:0]  intr2011REG,
    output logic        MisalignREG,
    output logic        state_dbg
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_LAT) + 1;
    // Counter value seen during the final cycle of an access.
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;

    logic           access;
    logic           is_store;
    logic           is_load;
    logic           misalign;
    logic           last_cycle;
    logic           commit;
    logic [AW-1:0]  idx;

    logic [31:0]    mem [MEM_WORDS];

    // -----------------------------------------------------------------------
    // Access decode
    // -----------------------------------------------------------------------
    always_comb begin
        access   = MemRead | MemWrite;
        is_store = MemWrite;
        is_load  = MemRead & ~MemWrite;   // store wins when both are set
`ifdef MEM_ALIGN_CHECK_EN
        misalign = access & (ALUresult[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        // cnt is 0 in IDLE, so with MEM_LAT=1 the first cycle is also the last.
        last_cycle = (cnt == LAST);
        commit     = access & ~misalign & last_cycle;
        idx        = ALUresult[AW+1:2];   // upper address bits wrap
        Stall      = ~rst & access & ~misalign & ~last_cycle;
        state_dbg  = (state == BUSY);
    end

    // -----------------------------------------------------------------------
    // FSM: next state and counter
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (access && !misalign && !last_cycle) begin
                    state_nxt = BUSY;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            BUSY: begin
                // Dropping the access mid-flight is a protocol error; recover
                // to IDLE rather than wait for a final cycle that never comes.
                if (!access || misalign || last_cycle) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // MEM/WB output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteREG  <= 1'b0;
            MemToRegREG  <= 1'b0;
            MisalignREG  <= 1'b0;
            ReadDataREG  <= '0;
            ALUresultREG <= '0;
            intr2011REG  <= '0;
        end else if (Stall) begin
            // Bubble: kill write-back controls, leave data untouched.
            RegWriteREG  <= 1'b0;
            MemToRegREG  <= 1'b0;
            MisalignREG  <= 1'b0;
        end else begin
            ALUresultREG <= ALUresult;
            intr2011REG  <= intr2011;
            if (misalign) begin
                RegWriteREG <= 1'b0;
                MemToRegREG <= 1'b0;
                MisalignREG <= 1'b1;
                ReadDataREG <= '0;
            end else begin
                RegWriteREG <= RegWrite;
                MemToRegREG <= MemToReg;
                MisalignREG <= 1'b0;
                ReadDataREG <= (commit && is_load) ? mem[idx] : 32'h0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Data memory: not reset; written only at the edge ending the final
    // cycle, so a reset mid-access discards the pending store.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && commit && is_store) begin
            mem[idx] <= ReadData2;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Two instances share one set of inputs: u2 (MEM_LAT=2, default) and
// u3 (MEM_LAT=3). A select flag chooses which instance's outputs are checked.
// The MEM_LAT=2 phase runs a vector table; the MEM_LAT=3 phase runs a few
// hand-written sequences including a reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

    // -------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        RegWrite, MemToReg, MemRead, MemWrite;
    logic [31:0] ALUresult, ReadData2;
    logic [4:0]  intr2011;

    logic        s2_stall, s2_rw, s2_m2r, s2_mis, s2_dbg;
    logic [31:0] s2_rdata, s2_alu;
    logic [4:0]  s2_dst;
    logic        s3_stall, s3_rw, s3_m2r, s3_mis, s3_dbg;
    logic [31:0] s3_rdata, s3_alu;
    logic [4:0]  s3_dst;

    mem_wb_stage u2 (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUresult(ALUresult), .ReadData2(ReadData2), .intr2011(intr2011),
        .Stall(s2_stall), .RegWriteREG(s2_rw), .MemToRegREG(s2_m2r),
        .ReadDataREG(s2_rdata), .ALUresultREG(s2_alu), .intr2011REG(s2_dst),
        .MisalignREG(s2_mis), .state_dbg(s2_dbg)
    );

    mem_wb_stage #(.MEM_WORDS(64), .MEM_LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUresult(ALUresult), .ReadData2(ReadData2), .intr2011(intr2011),
        .Stall(s3_stall), .RegWriteREG(s3_rw), .MemToRegREG(s3_m2r),
        .ReadDataREG(s3_rdata), .ALUresultREG(s3_alu), .intr2011REG(s3_dst),
        .MisalignREG(s3_mis), .state_dbg(s3_dbg)
    );

    logic        sel3;
    logic        o_stall, o_rw, o_m2r, o_mis, o_dbg;
    logic [31:0] o_rdata, o_alu;
    logic [4:0]  o_dst;

    assign o_stall = sel3 ? s3_stall : s2_stall;
    assign o_rw    = sel3 ? s3_rw    : s2_rw;
    assign o_m2r   = sel3 ? s3_m2r   : s2_m2r;
    assign o_mis   = sel3 ? s3_mis   : s2_mis;
    assign o_dbg   = sel3 ? s3_dbg   : s2_dbg;
    assign o_rdata = sel3 ? s3_rdata : s2_rdata;
    assign o_alu   = sel3 ? s3_alu   : s2_alu;
    assign o_dst   = sel3 ? s3_dst   : s2_dst;

    // -------------------------------------------------------------------
    // Vector record
    // -------------------------------------------------------------------
    typedef struct {
        logic        rw, m2r, mr, mw;
        logic [31:0] alu, rd2;
        logic [4:0]  dst;
        logic        e_rw, e_m2r, e_mis;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic m2r, input logic mr,
                                input logic mw, input logic [31:0] alu,
                                input logic [31:0] rd2, input logic [4:0] dst,
                                input logic e_rw, input logic e_m2r,
                                input logic e_mis, input logic [31:0] e_rdata);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.mr = mr; v.mw = mw;
        v.alu = alu; v.rd2 = rd2; v.dst = dst;
        v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_mis = e_mis; v.e_rdata = e_rdata;
        return v;
    endfunction

    // -------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    logic [31:0] prev_alu, prev_rdata;
    logic [4:0]  prev_dst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " stall"}, 32'(o_stall), 32'h0);
        chk({tag, " rw"},    32'(o_rw),    32'h0);
        chk({tag, " m2r"},   32'(o_m2r),   32'h0);
        chk({tag, " mis"},   32'(o_mis),   32'h0);
        chk({tag, " rdata"}, o_rdata,      32'h0);
        chk({tag, " alu"},   o_alu,        32'h0);
        chk({tag, " dst"},   32'(o_dst),   32'h0);
        chk({tag, " state"}, 32'(o_dbg),   32'h0);
    endtask

    // -------------------------------------------------------------------
    // Driver: present one instruction, hold it while stalled, check every
    // cycle's Stall, every bubble and the final write-back values.
    // Called and returns at posedge+1.
    // -------------------------------------------------------------------
    task automatic run_op(input vec_t v, input int lat, input string tag);
        int   nc;
        logic acc;
        RegWrite  = v.rw;
        MemToReg  = v.m2r;
        MemRead   = v.mr;
        MemWrite  = v.mw;
        ALUresult = v.alu;
        ReadData2 = v.rd2;
        intr2011  = v.dst;
        acc = v.mr | v.mw;
        nc  = acc ? lat : 1;
`ifdef MEM_ALIGN_CHECK_EN
        if (acc && v.alu[1:0] != 2'b00) nc = 1;
`endif
        for (int c = 1; c <= nc; c++) begin
            #1;
            chk($sformatf("%s c%0d stall", tag, c), 32'(o_stall), 32'(c < nc));
            @(posedge clk);
            #1;
            if (c < nc) begin
                chk($sformatf("%s c%0d bubble rw", tag, c),  32'(o_rw),  32'h0);
                chk($sformatf("%s c%0d bubble m2r", tag, c), 32'(o_m2r), 32'h0);
                chk($sformatf("%s c%0d bubble mis", tag, c), 32'(o_mis), 32'h0);
                chk($sformatf("%s c%0d hold alu", tag, c),   o_alu,      prev_alu);
                chk($sformatf("%s c%0d hold rdata", tag, c), o_rdata,    prev_rdata);
                chk($sformatf("%s c%0d hold dst", tag, c),   32'(o_dst), 32'(prev_dst));
            end
        end
        chk({tag, " rw"},    32'(o_rw),  32'(v.e_rw));
        chk({tag, " m2r"},   32'(o_m2r), 32'(v.e_m2r));
        chk({tag, " mis"},   32'(o_mis), 32'(v.e_mis));
        chk({tag, " rdata"}, o_rdata,    v.e_rdata);
        chk({tag, " alu"},   o_alu,      v.alu);
        chk({tag, " dst"},   32'(o_dst), 32'(v.dst));
        prev_alu   = v.alu;
        prev_rdata = v.e_rdata;
        prev_dst   = v.dst;
    endtask

    // -------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------
    // Test
    // -------------------------------------------------------------------
    vec_t tbl[13];

    initial begin
        // Table for MEM_LAT=2, MEM_WORDS=64
        tbl[0]  = mk(1, 0, 0, 0, 32'h55,       32'h0,        5'd7,  1, 0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 1, 32'h10,       32'hDEADBEEF, 5'd0,  0, 0, 0, 32'h0);
        tbl[2]  = mk(1, 1, 1, 0, 32'h10,       32'h0,        5'd3,  1, 1, 0, 32'hDEADBEEF);
        tbl[3]  = mk(0, 0, 0, 1, 32'h100,      32'h12345678, 5'd0,  0, 0, 0, 32'h0);
        tbl[4]  = mk(1, 1, 1, 0, 32'h0,        32'h0,        5'd9,  1, 1, 0, 32'h12345678);
        tbl[5]  = mk(0, 0, 1, 1, 32'h14,       32'hA5A50001, 5'd4,  0, 0, 0, 32'h0);
        tbl[6]  = mk(1, 1, 1, 0, 32'h14,       32'h0,        5'd4,  1, 1, 0, 32'hA5A50001);
        tbl[7]  = mk(0, 0, 0, 1, 32'hFC,       32'hCAFEF00D, 5'd0,  0, 0, 0, 32'h0);
        tbl[8]  = mk(1, 1, 1, 0, 32'h1FC,      32'h0,        5'd12, 1, 1, 0, 32'hCAFEF00D);
        tbl[9]  = mk(0, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        5'd31, 0, 1, 0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        tbl[10] = mk(1, 1, 1, 0, 32'h13,       32'h0,        5'd6,  0, 0, 1, 32'h0);
        tbl[11] = mk(0, 0, 0, 1, 32'h11,       32'h00000BAD, 5'd0,  0, 0, 1, 32'h0);
        tbl[12] = mk(1, 1, 1, 0, 32'h10,       32'h0,        5'd8,  1, 1, 0, 32'hDEADBEEF);
`else
        tbl[10] = mk(1, 1, 1, 0, 32'h13,       32'h0,        5'd6,  1, 1, 0, 32'hDEADBEEF);
        tbl[11] = mk(0, 0, 0, 1, 32'h11,       32'h00000BAD, 5'd0,  0, 0, 0, 32'h0);
        tbl[12] = mk(1, 1, 1, 0, 32'h10,       32'h0,        5'd8,  1, 1, 0, 32'h00000BAD);
`endif

        // Reset with an access on the inputs: Stall must stay low.
        sel3      = 1'b0;
        rst       = 1'b1;
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ALUresult = 32'h10;
        ReadData2 = 32'h77777777;
        intr2011  = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset u2");
        chk("reset u3 stall", 32'(s3_stall), 32'h0);

        RegWrite = 1'b0; MemToReg = 1'b0; MemWrite = 1'b0;
        ALUresult = 32'h0; ReadData2 = 32'h0; intr2011 = 5'd0;
        rst = 1'b0;
        prev_alu = 32'h0; prev_rdata = 32'h0; prev_dst = 5'd0;

        // MEM_LAT=2 table
        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i], 2, $sformatf("v%0d", i));
        end

        // MEM_LAT=3 phase
        sel3 = 1'b1;
        RegWrite = 1'b0; MemToReg = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_alu = 32'h0; prev_rdata = 32'h0; prev_dst = 5'd0;

        run_op(mk(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 0, 32'h0), 3, "l3 st10");
        run_op(mk(1, 1, 1, 0, 32'h10, 32'h0, 5'd5, 1, 1, 0, 32'hDEADBEEF), 3, "l3 ld10");
        run_op(mk(1, 0, 0, 0, 32'h55, 32'h0, 5'd7, 1, 0, 0, 32'h0), 3, "l3 alu");
        run_op(mk(0, 0, 0, 1, 32'h20, 32'h00001111, 5'd0, 0, 0, 0, 32'h0), 3, "l3 st20");

        // Store to 0x20 aborted by reset in its second cycle.
        RegWrite = 1'b0; MemToReg = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
        ALUresult = 32'h20; ReadData2 = 32'h00002222; intr2011 = 5'd0;
        #1;
        chk("abort c1 stall", 32'(o_stall), 32'h1);
        @(posedge clk);
        #1;
        chk("abort c2 state", 32'(o_dbg), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort rst stall", 32'(o_stall), 32'h0);
        @(posedge clk);
        #1;
        check_zero_outputs("abort");
        rst = 1'b0;
        prev_alu = 32'h0; prev_rdata = 32'h0; prev_dst = 5'd0;

        run_op(mk(1, 1, 1, 0, 32'h20, 32'h0, 5'd2, 1, 1, 0, 32'h00001111), 3, "l3 ld20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
